alu_seq_nbit: RTL and testbench



---
 rtl/alu_pkg.sv | 18 +
 rtl/muldiv_iter.sv | 75 +++++++
 rtl/alu_seq_nbit.sv | 135 +++++++++++++
 tb/tb_alu_seq_nbit.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for alu_seq_nbit: ALU-control op codes and the sequencer state type.
package alu_pkg;

  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_MULTU = 3'b011;
  localparam logic [2:0] ALU_DIVU  = 3'b100;
  localparam logic [2:0] ALU_SUB   = 3'b110;
  localparam logic [2:0] ALU_SLT   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider sharing one {acc,q} shift register.
// hi/lo present the register contents after the iteration performed this cycle.
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_reg, q_reg, opb_reg;
  logic [CW-1:0]    cnt_reg;
  logic             div_reg;

  logic [WIDTH:0]   add_a, add_b;
  logic             cin;
  logic [WIDTH+1:0] sum;
  logic [WIDTH-1:0] acc_next, q_next;

  // One WIDTH+1-bit adder: multiplicand add for MULTU, divisor subtract (carry = no borrow) for DIVU.
  always_comb begin
    add_a = {1'b0, acc_reg};
    add_b = '0;
    cin   = 1'b0;
    if (div_reg) begin
      add_a = {acc_reg, q_reg[WIDTH-1]};
      add_b = ~{1'b0, opb_reg};
      cin   = 1'b1;
    end else if (q_reg[0]) begin
      add_b = {1'b0, opb_reg};
    end
    sum = {1'b0, add_a} + {1'b0, add_b} + {{(WIDTH+1){1'b0}}, cin};

    if (div_reg) begin
      acc_next = sum[WIDTH+1] ? sum[WIDTH-1:0] : add_a[WIDTH-1:0];
      q_next   = {q_reg[WIDTH-2:0], sum[WIDTH+1]};
    end else begin
      acc_next = sum[WIDTH:1];
      q_next   = {sum[0], q_reg[WIDTH-1:1]};
    end
  end

  assign hi   = acc_next;
  assign lo   = q_next;
  assign last = (cnt_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg <= '0;
      q_reg   <= '0;
      opb_reg <= '0;
      div_reg <= 1'b0;
      cnt_reg <= '0;
    end else if (load) begin
      acc_reg <= '0;
      q_reg   <= a;
      opb_reg <= b;
      div_reg <= is_div;
      cnt_reg <= '0;
    end else begin
      acc_reg <= acc_next;
      q_reg   <= q_next;
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq_nbit.sv
// Registered N-bit ALU (AND/OR/ADD/SUB/SLT) with optional iterative MULTU/DIVU into HI/LO.
// Define ALU_MULDIV_EN to build the multiply/divide unit; otherwise 011/100 act as reserved ops.
module alu_seq_nbit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] first,
  input  logic [WIDTH-1:0] second,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] b_eff, sum, sc_result, fin_result;
  logic             sub_op, add_ovf, sc_ovf, fin_ovf, finish, is_long_op;
  logic [WIDTH-1:0] result_reg;
  logic             zero_reg, overflow_reg, done_reg;

  always_comb begin
    sub_op  = (op == ALU_SUB) || (op == ALU_SLT);
    b_eff   = sub_op ? ~second : second;
    sum     = first + b_eff + {{(WIDTH-1){1'b0}}, sub_op};
    add_ovf = (first[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != first[WIDTH-1]);

    sc_result = '0;
    sc_ovf    = 1'b0;
    case (op)
      ALU_AND: sc_result = first & second;
      ALU_OR:  sc_result = first | second;
      ALU_ADD, ALU_SUB: begin
        sc_result = sum;
        sc_ovf    = add_ovf;
      end
      // Sign corrected by overflow keeps the compare right across the wrap boundary.
      ALU_SLT: sc_result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_ovf};
      default: sc_result = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  state_t           state_reg, state_next;
  logic [WIDTH-1:0] hi_reg, lo_reg, iter_hi, iter_lo;
  logic             iter_last, load;

  assign is_long_op = (op == ALU_MULTU) || (op == ALU_DIVU);
  assign busy       = (state_reg != ST_IDLE);
  assign load       = start && !busy && is_long_op;
  assign finish     = busy && iter_last;
  assign fin_result = iter_lo;
  assign fin_ovf    = (state_reg == ST_MUL) && (iter_hi != '0);
  assign hi         = hi_reg;
  assign lo         = lo_reg;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (load) state_next = (op == ALU_MULTU) ? ST_MUL : ST_DIV;
      ST_MUL, ST_DIV: if (iter_last) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .is_div (op == ALU_DIVU),
    .a      (first),
    .b      (second),
    .hi     (iter_hi),
    .lo     (iter_lo),
    .last   (iter_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (finish) begin
      hi_reg <= iter_hi;
      lo_reg <= iter_lo;
    end
  end
`else
  assign is_long_op = 1'b0;
  assign busy       = 1'b0;
  assign finish     = 1'b0;
  assign fin_result = '0;
  assign fin_ovf    = 1'b0;
  assign hi         = '0;
  assign lo         = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      result_reg   <= '0;
      zero_reg     <= 1'b1;
      overflow_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (finish) begin
        result_reg   <= fin_result;
        zero_reg     <= (fin_result == '0);
        overflow_reg <= fin_ovf;
        done_reg     <= 1'b1;
      end else if (start && !busy && !is_long_op) begin
        result_reg   <= sc_result;
        zero_reg     <= (sc_result == '0);
        overflow_reg <= sc_ovf;
        done_reg     <= 1'b1;
      end
    end
  end

  assign result   = result_reg;
  assign zero     = zero_reg;
  assign overflow = overflow_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_alu_seq_nbit.sv
// Directed, table-driven bench for alu_seq_nbit at WIDTH=32; the multiply/divide
// sequences run when ALU_MULDIV_EN is defined, otherwise 011/100 are checked as reserved ops.
module tb_alu_seq_nbit;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] first, second, result, hi, lo;
  logic        zero, overflow, busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        z;
    logic        ov;
  } vec_t;
  vec_t vecs[$];

  alu_seq_nbit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .first    (first),
    .second   (second),
    .result   (result),
    .zero     (zero),
    .overflow (overflow),
    .hi       (hi),
    .lo       (lo),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " result"}, result, 0);
    chk({tag, " zero"}, zero, 1);
    chk({tag, " overflow"}, overflow, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " done"}, done, 0);
    chk({tag, " hi"}, hi, 0);
    chk({tag, " lo"}, lo, 0);
  endtask

`ifdef ALU_MULDIV_EN
  // Starts a MULTU/DIVU, pokes ignored starts during busy, checks the done cycle.
  task automatic run_long(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic eov,
                          input string nm);
    op = o; first = a; second = b; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      chk($sformatf("%s busy c%0d", nm, k), busy, 1);
      chk($sformatf("%s done c%0d", nm, k), done, 0);
      if (k == 5 || k == 32) begin
        start = 1'b1; op = ALU_ADD; first = 32'h1; second = 32'h1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    exp_hi = ehi;
    exp_lo = elo;
    chk({nm, " done"}, done, 1);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " hi"}, hi, ehi);
    chk({nm, " lo"}, lo, elo);
    chk({nm, " result"}, result, elo);
    chk({nm, " zero"}, zero, (elo == 0));
    chk({nm, " overflow"}, overflow, eov);
    $display("%s a=0x%08h b=0x%08h -> hi=0x%08h lo=0x%08h ovf=%0b", nm, a, b, hi, lo, overflow);
    step();
    chk({nm, " done drops"}, done, 0);
    chk({nm, " result holds"}, result, elo);
  endtask
`endif

  initial begin
    vecs.push_back('{ALU_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1});
    vecs.push_back('{ALU_SLT, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0});
    vecs.push_back('{ALU_SLT, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{ALU_SUB, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{ALU_AND, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0});
    vecs.push_back('{ALU_OR,  32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0});
    vecs.push_back('{ALU_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1});
    vecs.push_back('{ALU_ADD, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{ALU_SLT, 32'h00000003, 32'h00000005, 32'h00000001, 1'b0, 1'b0});
    vecs.push_back('{ALU_SLT, 32'h00000005, 32'h00000003, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{3'b101,  32'hDEADBEEF, 32'h12345678, 32'h00000000, 1'b1, 1'b0});
`ifndef ALU_MULDIV_EN
    vecs.push_back('{ALU_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{ALU_DIVU,  32'h00000064, 32'h00000007, 32'h00000000, 1'b1, 1'b0});
`endif

    reset = 1'b1; start = 1'b0; op = ALU_AND; first = '0; second = '0;
    step();
    step();
    reset = 1'b0;
    chk_reset_state("reset");

    // Back-to-back single-cycle ops: each result lands one cycle after its start.
    foreach (vecs[i]) begin
      op = vecs[i].op; first = vecs[i].a; second = vecs[i].b; start = 1'b1;
      step();
      $display("op=%03b a=0x%08h b=0x%08h -> result=0x%08h zero=%0b ovf=%0b done=%0b",
               vecs[i].op, vecs[i].a, vecs[i].b, result, zero, overflow, done);
      chk($sformatf("vec%0d result", i), result, vecs[i].res);
      chk($sformatf("vec%0d zero", i), zero, vecs[i].z);
      chk($sformatf("vec%0d overflow", i), overflow, vecs[i].ov);
      chk($sformatf("vec%0d done", i), done, 1);
      chk($sformatf("vec%0d busy", i), busy, 0);
      chk($sformatf("vec%0d hi", i), hi, exp_hi);
      chk($sformatf("vec%0d lo", i), lo, exp_lo);
    end
    start = 1'b0;
    step();
    chk("idle done", done, 0);
    chk("idle result holds", result, vecs[vecs.size()-1].res);

`ifdef ALU_MULDIV_EN
    run_long(ALU_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b1, "MULTU");
    run_long(ALU_MULTU, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F, 1'b0, "MULTU small");
    run_long(ALU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, "DIVU");
    run_long(ALU_DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, 1'b0, "DIVU by0");

    // Reserved op leaves hi/lo untouched.
    op = 3'b101; first = 32'h5; second = 32'h6; start = 1'b1;
    step();
    start = 1'b0;
    $display("reserved after DIVU -> result=0x%08h hi=0x%08h lo=0x%08h", result, hi, lo);
    chk("rsv result", result, 0);
    chk("rsv zero", zero, 1);
    chk("rsv done", done, 1);
    chk("rsv hi", hi, exp_hi);
    chk("rsv lo", lo, exp_lo);

    // Reset in cycle 10 of a MULTU aborts it.
    op = ALU_MULTU; first = 32'h12345678; second = 32'h9; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k < 10; k++) step();
    chk("abort busy c10", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_state("abort");
    exp_hi = '0;
    exp_lo = '0;
    op = ALU_ADD; first = 32'd2; second = 32'd3; start = 1'b1;
    step();
    start = 1'b0;
    $display("ADD after abort -> result=0x%08h done=%0b", result, done);
    chk("post-abort add result", result, 5);
    chk("post-abort add done", done, 1);
    chk("post-abort add busy", busy, 0);
    for (int k = 0; k < 40; k++) begin
      step();
      if (done !== 1'b0 || busy !== 1'b0) chk($sformatf("no stray done c%0d", k), {done, busy}, 0);
    end
    chk("post-abort quiet hi", hi, 0);
`else
    // Without the unit, a MULTU start completes at once with no busy phase.
    op = ALU_MULTU; first = 32'h3; second = 32'h5; start = 1'b1;
    step();
    start = 1'b0;
    $display("MULTU disabled -> result=0x%08h busy=%0b done=%0b", result, busy, done);
    chk("nomd busy", busy, 0);
    chk("nomd done", done, 1);
    chk("nomd hi", hi, 0);
    chk("nomd lo", lo, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk_reset_state("nomd reset");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
